fetch: RTL

- Instruction fetch stage of the 5-stage Beta pipeline; sits directly upstream of decode and drives its `pc` (PC+4) and `ir` inputs.
- Issues instruction-memory requests ahead of decode and buffers returned words in a small in-order FIFO.
- Applies decode's stall and branch/jump redirects, and squashes wrong-path instructions, including responses still in flight.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the instruction-buffer entry type for the fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // ADD R31,R31,R31: the bubble presented to decode when there is nothing valid.
    localparam logic [XLEN-1:0] INST_NOP             = 32'h83FF_F800;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;

    // One buffered instruction together with the PC+4 decode expects alongside it.
    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: synchronous FIFO with push, pop and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  fetch_entry_t                   i_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output fetch_entry_t                   o_head,
    output logic [$clog2(DEPTH):0]         o_count,
    output logic                           o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;

    // Pointer and occupancy tracking; flush empties the buffer in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign w_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Credit accounting upstream must make overflow and underflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && w_full && !i_pop && !i_flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && o_empty));

endmodule

// File: rtl/fetch.sv
// Beta pipeline instruction fetch: prefetches into a small buffer, applies
// decode stalls and redirects, and squashes wrong-path responses in flight.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        op_jmp,
    input  logic        op_beq,
    input  logic        op_bne,
    input  logic        zr,
    input  logic [31:0] j_addr,
    input  logic [31:0] br_addr,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        redirect
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_rsp_addr;
    logic [31:0]   r_pc_hold;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_kill_cnt;

    logic          w_redirect;
    logic [31:0]   w_target;
    logic [CW:0]   w_inflight;
    logic          w_req_valid;
    logic          w_fire;
    logic          w_kill;
    logic          w_push;
    logic          w_present;
    logic          w_pop;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Redirect decision, request credit check and buffer handshakes.
    always_comb begin
        w_redirect   = rst & ~stall & (op_jmp | (op_beq & zr) | (op_bne & ~zr));
        w_target     = op_jmp ? (j_addr & 32'hFFFF_FFFC) : br_addr;
        w_inflight   = (CW+1)'(r_out_cnt) + (CW+1)'(w_fifo_count);
        w_req_valid  = rst & ~w_redirect & (w_inflight < (CW+1)'(FIFO_DEPTH));
        w_fire       = w_req_valid & imem_req_ready;
        w_kill       = imem_rsp_valid & (r_kill_cnt != '0);
        w_push       = imem_rsp_valid & ~w_kill & ~w_redirect;
        w_present    = ~w_fifo_empty & ~w_redirect;
        w_pop        = w_present & ~stall;
        w_push_entry.pc4   = r_rsp_addr + 32'd4;
        w_push_entry.instr = imem_rsp_data;
    end

    // Address, credit and squash bookkeeping; a redirect retargets both address streams.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_addr <= RESET_VECTOR;
            r_rsp_addr   <= RESET_VECTOR;
            r_out_cnt    <= '0;
            r_kill_cnt   <= '0;
            r_pc_hold    <= RESET_VECTOR;
        end else begin
            if (w_redirect) begin
                r_fetch_addr <= w_target;
                r_rsp_addr   <= w_target;
                r_kill_cnt   <= r_out_cnt - CW'(imem_rsp_valid);
            end else begin
                if (w_fire) r_fetch_addr <= r_fetch_addr + 32'd4;
                if (w_push) r_rsp_addr   <= r_rsp_addr + 32'd4;
                if (w_kill) r_kill_cnt   <= r_kill_cnt - CW'(1);
            end
            r_out_cnt <= r_out_cnt + CW'(w_fire) - CW'(imem_rsp_valid);
            if (w_present) r_pc_hold <= w_head.pc4;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_fetch_addr;
    assign redirect       = w_redirect;
    assign ir             = w_present ? w_head.instr : INST_NOP;
    assign pc             = w_present ? w_head.pc4   : r_pc_hold;

endmodule
